// File: rtl/hazard_fwd_unit_if.sv
// Decode-side and control-side signal bundle for hazard_fwd_unit.
// The ID stage drives the master side; the hazard unit sits on the slave side.
interface hazard_fwd_unit_if #(
  parameter int AW   = 5,
  parameter int SELW = 2
);
  logic            id_valid;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wen;
  logic [AW-1:0]   id_wreg;
  logic            id_is_load;
  logic            redirect;
  logic            stall;
  logic            flush_id;
  logic            bubble;
  logic [SELW-1:0] fwd_a_sel;
  logic [SELW-1:0] fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_wen, id_wreg, id_is_load, redirect,
    input  stall, flush_id, bubble, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_wen, id_wreg, id_is_load, redirect,
    output stall, flush_id, bubble, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard, forwarding and flush controller with an EX..WB scoreboard of N = MEM_STAGES+2 slots.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/forward event counters.
module hazard_fwd_unit #(
  parameter  int AW           = 5,
  parameter  int MEM_STAGES   = 1,
  parameter  int RESOLVE_SLOT = 2,
  localparam int N            = MEM_STAGES + 2,
  localparam int SELW         = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_unit_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events,
  output logic [31:0]      fwd_events
`endif
);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] wreg;
    logic          is_load;
    logic          use_rs;
    logic          use_rt;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } slot_t;

  slot_t           slot_q [1:N];
  slot_t           slot_d [1:N];
  slot_t           id_entry;
  logic            load_hit;
  logic            stall_w;
  logic [SELW-1:0] fwd_a_w;
  logic [SELW-1:0] fwd_b_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= N; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Load data is only forwardable from WB, so a consumer waits while the load sits in slots 1..N-2.
  always_comb begin
    load_hit = 1'b0;
    for (int s = 1; s <= N - 2; s++) begin
      if (slot_q[s].valid && slot_q[s].wen && slot_q[s].is_load &&
          (slot_q[s].wreg != '0) &&
          ((hif.id_use_rs && (slot_q[s].wreg == hif.id_rs)) ||
           (hif.id_use_rt && (slot_q[s].wreg == hif.id_rt)))) begin
        load_hit = 1'b1;
      end
    end
  end

  assign stall_w = hif.id_valid & ~hif.redirect & load_hit;

  // Walk oldest to youngest so the youngest matching producer overwrites older ones.
  always_comb begin
    fwd_a_w = '0;
    fwd_b_w = '0;
    if (slot_q[1].valid) begin
      for (int k = N; k >= 2; k--) begin
        if (slot_q[k].valid && slot_q[k].wen) begin
          if (slot_q[1].use_rs && (slot_q[1].rs != '0) &&
              (slot_q[k].wreg == slot_q[1].rs)) begin
            fwd_a_w = SELW'(k - 1);
          end
          if (slot_q[1].use_rt && (slot_q[1].rt != '0) &&
              (slot_q[k].wreg == slot_q[1].rt)) begin
            fwd_b_w = SELW'(k - 1);
          end
        end
      end
    end
  end

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.wen     = hif.id_wen;
    id_entry.wreg    = hif.id_wreg;
    id_entry.is_load = hif.id_is_load;
    id_entry.use_rs  = hif.id_use_rs;
    id_entry.use_rt  = hif.id_use_rt;
    id_entry.rs      = hif.id_rs;
    id_entry.rt      = hif.id_rt;
  end

  // Younger-than-resolver entries are squashed as they shift; the resolver and older continue.
  always_comb begin
    for (int k = 1; k <= N; k++) begin
      slot_d[k] = '0;
    end
    if (hif.id_valid && !stall_w && !hif.redirect) begin
      slot_d[1] = id_entry;
    end
    for (int k = 1; k <= N - 1; k++) begin
      if (hif.redirect && (k < RESOLVE_SLOT)) begin
        slot_d[k+1] = '0;
      end else begin
        slot_d[k+1] = slot_q[k];
      end
    end
  end

  assign hif.stall     = stall_w;
  assign hif.flush_id  = hif.redirect & rst_n;
  assign hif.bubble    = (stall_w | hif.redirect) & rst_n;
  assign hif.fwd_a_sel = fwd_a_w;
  assign hif.fwd_b_sel = fwd_b_w;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_events_q;
  logic [31:0] flush_events_d;
  logic [31:0] fwd_events_q;
  logic [31:0] fwd_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    fwd_events_d   = fwd_events_q;
    if (stall_w && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (hif.redirect && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
    if (((fwd_a_w != '0) || (fwd_b_w != '0)) && (fwd_events_q != '1)) begin
      fwd_events_d = fwd_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: dut0 uses default parameters, dut1 uses MEM_STAGES=3.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_hazard_fwd_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_fwd_unit_if #(.AW(5), .SELW(2)) hif0 ();
  hazard_fwd_unit_if #(.AW(5), .SELW(3)) hif1 ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles0, flushEvents0, fwdEvents0;
  logic [31:0] stallCycles1, flushEvents1, fwdEvents1;
`endif

  hazard_fwd_unit #(.AW(5), .MEM_STAGES(1), .RESOLVE_SLOT(2)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .hif          (hif0)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stallCycles0),
    .flush_events (flushEvents0),
    .fwd_events   (fwdEvents0)
`endif
  );

  hazard_fwd_unit #(.AW(5), .MEM_STAGES(3), .RESOLVE_SLOT(2)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .hif          (hif1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stallCycles1),
    .flush_events (flushEvents1),
    .fwd_events   (fwdEvents1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One cycle: wait for the falling edge, drive the ID slot of the chosen DUT, settle.
  task automatic applyStimulus(input int which, input logic valid,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic useRs, input logic useRt,
                               input logic wen, input logic [4:0] wreg,
                               input logic isLoad, input logic redirect);
    @(negedge clk);
    if (which == 0) begin
      hif0.id_valid = valid;   hif0.id_rs = rs;        hif0.id_rt = rt;
      hif0.id_use_rs = useRs;  hif0.id_use_rt = useRt; hif0.id_wen = wen;
      hif0.id_wreg = wreg;     hif0.id_is_load = isLoad; hif0.redirect = redirect;
    end else begin
      hif1.id_valid = valid;   hif1.id_rs = rs;        hif1.id_rt = rt;
      hif1.id_use_rs = useRs;  hif1.id_use_rt = useRt; hif1.id_wen = wen;
      hif1.id_wreg = wreg;     hif1.id_is_load = isLoad; hif1.redirect = redirect;
    end
    #1;
  endtask

  task automatic idleCycles(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(which, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    hif0.id_valid = 0; hif0.id_rs = 0; hif0.id_rt = 0; hif0.id_use_rs = 0;
    hif0.id_use_rt = 0; hif0.id_wen = 0; hif0.id_wreg = 0; hif0.id_is_load = 0;
    hif0.redirect = 0;
    hif1.id_valid = 0; hif1.id_rs = 0; hif1.id_rt = 0; hif1.id_use_rs = 0;
    hif1.id_use_rt = 0; hif1.id_wen = 0; hif1.id_wreg = 0; hif1.id_is_load = 0;
    hif1.redirect = 0;

    $display("[TB] reset state");
    idleCycles(0, 1);
    checkOutput("rst_stall0", 32'(hif0.stall), 0);
    checkOutput("rst_flush0", 32'(hif0.flush_id), 0);
    checkOutput("rst_bubble0", 32'(hif0.bubble), 0);
    checkOutput("rst_fwda0", 32'(hif0.fwd_a_sel), 0);
    checkOutput("rst_fwdb1", 32'(hif1.fwd_b_sel), 0);
    rst_n = 1'b1;

    $display("[TB] ALU to ALU forward");
    applyStimulus(0, 1, 1, 2, 1, 1, 1, 3, 0, 0);          // add $3,$1,$2
    checkOutput("alu_stallA", 32'(hif0.stall), 0);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0);          // sub $4,$3,$1
    checkOutput("alu_stallB", 32'(hif0.stall), 0);
    checkOutput("alu_fwdaB", 32'(hif0.fwd_a_sel), 0);
    idleCycles(0, 1);
    checkOutput("alu_fwda", 32'(hif0.fwd_a_sel), 1);
    checkOutput("alu_fwdb", 32'(hif0.fwd_b_sel), 0);
    checkOutput("alu_stallC", 32'(hif0.stall), 0);
    idleCycles(0, 3);

    $display("[TB] load-use default depth");
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 5, 1, 0);          // lw $5,0($0)
    checkOutput("lu_stallA", 32'(hif0.stall), 0);
    applyStimulus(0, 1, 5, 5, 1, 1, 1, 6, 0, 0);          // add $6,$5,$5
    checkOutput("lu_stallB", 32'(hif0.stall), 1);
    checkOutput("lu_bubbleB", 32'(hif0.bubble), 1);
    checkOutput("lu_flushB", 32'(hif0.flush_id), 0);
    applyStimulus(0, 1, 5, 5, 1, 1, 1, 6, 0, 0);          // held in ID
    checkOutput("lu_stallC", 32'(hif0.stall), 0);
    checkOutput("lu_bubbleC", 32'(hif0.bubble), 0);
    idleCycles(0, 1);
    checkOutput("lu_fwda", 32'(hif0.fwd_a_sel), 2);
    checkOutput("lu_fwdb", 32'(hif0.fwd_b_sel), 2);
    idleCycles(0, 3);

    $display("[TB] load-use with three memory stages");
    applyStimulus(1, 1, 0, 0, 1, 0, 1, 7, 1, 0);          // lw $7
    checkOutput("m3_stallA", 32'(hif1.stall), 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 7, 0, 1, 1, 1, 10, 0, 0);       // add $10,$7,$0
      checkOutput("m3_stall_hold", 32'(hif1.stall), 1);
    end
    applyStimulus(1, 1, 7, 0, 1, 1, 1, 10, 0, 0);
    checkOutput("m3_stall_end", 32'(hif1.stall), 0);
    idleCycles(1, 1);
    checkOutput("m3_fwda", 32'(hif1.fwd_a_sel), 4);
    checkOutput("m3_fwdb", 32'(hif1.fwd_b_sel), 0);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("m3_stall_cnt", stallCycles1, 3);
    checkOutput("m3_fwd_cnt0", fwdEvents1, 0);
    idleCycles(1, 1);
    checkOutput("m3_fwd_cnt1", fwdEvents1, 1);
    checkOutput("m3_flush_cnt", flushEvents1, 0);
`endif
    idleCycles(1, 5);

    $display("[TB] redirect beats load-use");
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 8, 1, 0);          // lw $8
    applyStimulus(0, 1, 8, 1, 1, 1, 1, 11, 0, 1);         // add $11,$8,$1 + redirect
    checkOutput("rd_stall", 32'(hif0.stall), 0);
    checkOutput("rd_flush", 32'(hif0.flush_id), 1);
    checkOutput("rd_bubble", 32'(hif0.bubble), 1);
    applyStimulus(0, 1, 8, 8, 1, 1, 1, 12, 0, 0);         // target: add $12,$8,$8
    checkOutput("rd_stall_after", 32'(hif0.stall), 0);
    checkOutput("rd_flush_after", 32'(hif0.flush_id), 0);
    idleCycles(0, 1);
    checkOutput("rd_fwda", 32'(hif0.fwd_a_sel), 0);
    checkOutput("rd_fwdb", 32'(hif0.fwd_b_sel), 0);
    idleCycles(0, 3);

    $display("[TB] register zero");
    applyStimulus(0, 1, 1, 2, 1, 1, 1, 0, 0, 0);          // add $0,$1,$2
    applyStimulus(0, 1, 0, 0, 1, 1, 1, 9, 0, 0);          // add $9,$0,$0
    checkOutput("z_stallB", 32'(hif0.stall), 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);          // lw $0,0($0)
    checkOutput("z_fwda", 32'(hif0.fwd_a_sel), 0);
    checkOutput("z_fwdb", 32'(hif0.fwd_b_sel), 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 1, 13, 0, 0);         // reads $0 after lw $0
    checkOutput("z_load_stall", 32'(hif0.stall), 0);
    idleCycles(0, 3);

    $display("[TB] reset during stall");
    applyStimulus(1, 1, 0, 0, 1, 0, 1, 7, 1, 0);          // lw $7
    applyStimulus(1, 1, 7, 7, 1, 1, 1, 14, 0, 0);         // consumer of $7
    checkOutput("rs_stall_pre", 32'(hif1.stall), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_stall_async", 32'(hif1.stall), 0);
    checkOutput("rs_bubble_async", 32'(hif1.bubble), 0);
    idleCycles(1, 1);
    rst_n = 1'b1;
    idleCycles(1, 1);
    checkOutput("rs_fwda", 32'(hif1.fwd_a_sel), 0);
    checkOutput("rs_fwdb", 32'(hif1.fwd_b_sel), 0);
    checkOutput("rs_stall_post", 32'(hif1.stall), 0);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("rs_stall_cnt", stallCycles1, 0);
    checkOutput("rs_flush_cnt", flushEvents1, 0);
    checkOutput("rs_fwd_cnt", fwdEvents1, 0);
    checkOutput("rs_stall_cnt0", stallCycles0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
